// File: rtl/nibble_packer.sv
// Packs a serial stream of 4-bit values into 16-bit words (first nibble in [15:12]) behind a
// one-entry registered valid/ready output. Optional word/pad counters: NIBBLE_PACKER_STATS_EN.
module nibble_packer #(
   parameter logic [3:0] PAD = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready
`ifdef NIBBLE_PACKER_STATS_EN
   ,
   output logic [7:0]  word_count,
   output logic [7:0]  pad_count
`endif
);

   // Writes nibble d at position k; on completion every later position takes PAD.
   function automatic logic [15:0] pack_word(input logic [15:0] acc,
                                             input logic [1:0]  k,
                                             input logic [3:0]  d,
                                             input logic        complete);
      logic [15:0] w;
      w = acc;
      for (int i = 0; i < 4; i++) begin
         if (i == int'(k)) begin
            w[15-4*i -: 4] = d;
         end else if ((i > int'(k)) && complete) begin
            w[15-4*i -: 4] = PAD;
         end else begin
            w[15-4*i -: 4] = acc[15-4*i -: 4];
         end
      end
      return w;
   endfunction

   logic [15:0] acc_q, acc_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        pend_q, pend_d;
   logic [15:0] obuf_q, obuf_d;
   logic        ovalid_q, ovalid_d;

   logic        accept_s;
   logic        emit_s;
   logic        slot_free_s;
   logic        complete_s;
   logic        load_s;
   logic [15:0] word_s;
   logic [15:0] load_word_s;

`ifdef NIBBLE_PACKER_STATS_EN
   logic [7:0]  word_count_q, word_count_d;
   logic [7:0]  pad_count_q, pad_count_d;
   logic        apad_q, apad_d;
   logic        opad_q, opad_d;
   logic        padded_s;
   logic        load_pad_s;
`endif

   // Handshake decode and next-state for accumulator, pending flag and output register.
   always_comb begin
      accept_s    = in_valid & ~pend_q;
      emit_s      = ovalid_q & out_ready;
      slot_free_s = ~ovalid_q | out_ready;
      complete_s  = accept_s & ((cnt_q == 2'd3) | in_last);
      word_s      = pack_word(acc_q, cnt_q, in_data, complete_s);

      acc_d       = acc_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      obuf_d      = obuf_q;
      ovalid_d    = ovalid_q;
      load_s      = 1'b0;
      load_word_s = acc_q;

      // A held word always drains first; no nibble can be accepted while it waits.
      if (pend_q) begin
         if (slot_free_s) begin
            load_s      = 1'b1;
            load_word_s = acc_q;
            pend_d      = 1'b0;
            acc_d       = 16'h0000;
         end else begin
            pend_d      = 1'b1;
         end
      end else if (complete_s) begin
         cnt_d = 2'd0;
         if (slot_free_s) begin
            load_s      = 1'b1;
            load_word_s = word_s;
            acc_d       = 16'h0000;
         end else begin
            acc_d  = word_s;
            pend_d = 1'b1;
         end
      end else if (accept_s) begin
         acc_d = word_s;
         cnt_d = cnt_q + 2'd1;
      end else begin
         acc_d = acc_q;
      end

      if (load_s) begin
         obuf_d   = load_word_s;
         ovalid_d = 1'b1;
      end else if (emit_s) begin
         ovalid_d = 1'b0;
      end else begin
         ovalid_d = ovalid_q;
      end
   end

   // Packing state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= 16'h0000;
         cnt_q    <= 2'd0;
         pend_q   <= 1'b0;
         obuf_q   <= 16'h0000;
         ovalid_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         obuf_q   <= obuf_d;
         ovalid_q <= ovalid_d;
      end
   end

   assign in_ready  = ~pend_q;
   assign out_data  = obuf_q;
   assign out_valid = ovalid_q;

`ifdef NIBBLE_PACKER_STATS_EN
   // Padding is tracked as a flag alongside the word, so a real PAD-valued nibble never counts.
   always_comb begin
      padded_s     = complete_s & (cnt_q != 2'd3);
      apad_d       = apad_q;
      opad_d       = opad_q;
      load_pad_s   = apad_q;
      word_count_d = word_count_q;
      pad_count_d  = pad_count_q;

      if (pend_q) begin
         load_pad_s = apad_q;
      end else if (complete_s && !slot_free_s) begin
         apad_d     = padded_s;
         load_pad_s = padded_s;
      end else begin
         load_pad_s = padded_s;
      end

      if (load_s) begin
         opad_d = load_pad_s;
      end else begin
         opad_d = opad_q;
      end

      if (emit_s) begin
         word_count_d = word_count_q + 8'd1;
         if (opad_q) begin
            pad_count_d = pad_count_q + 8'd1;
         end else begin
            pad_count_d = pad_count_q;
         end
      end else begin
         word_count_d = word_count_q;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         apad_q       <= 1'b0;
         opad_q       <= 1'b0;
         word_count_q <= 8'd0;
         pad_count_q  <= 8'd0;
      end else begin
         apad_q       <= apad_d;
         opad_q       <= opad_d;
         word_count_q <= word_count_d;
         pad_count_q  <= pad_count_d;
      end
   end

   assign word_count = word_count_q;
   assign pad_count  = pad_count_q;
`endif

endmodule

// File: tb/tb_nibble_packer.sv
// Directed and randomized bench for nibble_packer against a queue-based word model.
module tb_nibble_packer;

   logic        clk;
   logic        rst;
   logic [3:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
`ifdef NIBBLE_PACKER_STATS_EN
   logic [7:0]  word_count;
   logic [7:0]  pad_count;
`endif

   nibble_packer dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef NIBBLE_PACKER_STATS_EN
      ,
      .word_count(word_count),
      .pad_count (pad_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: nibbles of the word being built, and completed words not yet emitted.
   logic [3:0]  cur[$];
   logic [15:0] wq[$];
   bit          pq[$];
   int          wcount = 0;
   int          pcount = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      cur.delete();
      wq.delete();
      pq.delete();
      wcount = 0;
      pcount = 0;
   endtask

   // One clock cycle: drive, check outputs against the model, clock, update model.
   task automatic cycle(input bit v, input logic [3:0] d, input bit l, input bit ordy);
      bit          acc;
      bit          em;
      logic [15:0] w;
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = ordy;
      #1;
      chk("in_ready", 32'(in_ready), 32'(wq.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(wq.size() > 0));
      if (wq.size() > 0) chk("out_data", 32'(out_data), 32'(wq[0]));
      acc = v && (wq.size() < 2);
      em  = (wq.size() > 0) && ordy;
      @(posedge clk);
      #1;
      if (em) begin
         wcount++;
         if (pq[0]) pcount++;
         void'(wq.pop_front());
         void'(pq.pop_front());
      end
      if (acc) begin
         cur.push_back(d);
         if (cur.size() == 4 || l) begin
            for (int i = 0; i < 4; i++) begin
               w[15-4*i -: 4] = (i < cur.size()) ? cur[i] : 4'hF;
            end
            wq.push_back(w);
            pq.push_back(cur.size() < 4);
            cur.delete();
         end
      end
`ifdef NIBBLE_PACKER_STATS_EN
      chk("word_count", 32'(word_count), 32'(wcount % 256));
      chk("pad_count", 32'(pad_count), 32'(pcount % 256));
`endif
      @(negedge clk);
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      in_data   = 4'h0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      model_clear();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'h0000);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef NIBBLE_PACKER_STATS_EN
      chk("rst_word_count", 32'(word_count), 32'd0);
      chk("rst_pad_count", 32'(pad_count), 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);
   endtask

   logic [3:0] seq_a[4];
   logic [3:0] rnd_d;

   initial begin
      rst = 1'b0;
      @(negedge clk);
      do_reset();

      // Full word A371, emitted one cycle after its fourth nibble.
      seq_a = '{4'hA, 4'h3, 4'h7, 4'h1};
      for (int i = 0; i < 4; i++) cycle(1'b1, seq_a[i], 1'b0, 1'b1);
      chk("a371_valid", 32'(out_valid), 32'd1);
      chk("a371_data", 32'(out_data), 32'hA371);
      cycle(1'b0, 4'h0, 1'b0, 1'b1);
      chk("a371_drop", 32'(out_valid), 32'd0);

      // Partial words: last on first nibble, then last on third.
      do_reset();
      cycle(1'b1, 4'h5, 1'b1, 1'b0);
      chk("p5_data", 32'(out_data), 32'h5FFF);
      cycle(1'b1, 4'h2, 1'b0, 1'b1);
      cycle(1'b1, 4'h9, 1'b1, 1'b0);
      chk("p29_data", 32'(out_data), 32'h29FF);
      cycle(1'b0, 4'h0, 1'b0, 1'b1);
      cycle(1'b0, 4'h0, 1'b0, 1'b1);
`ifdef NIBBLE_PACKER_STATS_EN
      chk("p_word_count", 32'(word_count), 32'd2);
      chk("p_pad_count", 32'(pad_count), 32'd2);
`endif

      // Backpressure: second word held pending, then back-to-back drain.
      do_reset();
      for (int i = 1; i <= 8; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_data", 32'(out_data), 32'h1234);
      cycle(1'b0, 4'h0, 1'b0, 1'b0);
      chk("bp_stable", 32'(out_data), 32'h1234);
      cycle(1'b0, 4'h0, 1'b0, 1'b1);
      chk("bp_no_bubble", 32'(out_valid), 32'd1);
      chk("bp_second", 32'(out_data), 32'h5678);
      chk("bp_ready_back", 32'(in_ready), 32'd1);
      cycle(1'b0, 4'h0, 1'b0, 1'b1);

      // Continuous stream 0..B at full rate.
      do_reset();
      for (int i = 0; i < 12; i++) cycle(1'b1, 4'(i), 1'b0, 1'b1);
      chk("cont_last", 32'(out_data), 32'h89AB);
      cycle(1'b0, 4'h0, 1'b0, 1'b1);

      // Reset mid-word discards the partial 6,E.
      cycle(1'b1, 4'h6, 1'b0, 1'b1);
      cycle(1'b1, 4'hE, 1'b0, 1'b1);
      do_reset();
      cycle(1'b1, 4'hC, 1'b0, 1'b1);
      cycle(1'b1, 4'hD, 1'b0, 1'b1);
      cycle(1'b1, 4'hE, 1'b0, 1'b1);
      chk("mid_rst_empty", 32'(out_valid), 32'd0);
      cycle(1'b1, 4'hF, 1'b0, 1'b1);
      chk("mid_rst_word", 32'(out_data), 32'hCDEF);
      cycle(1'b0, 4'h0, 1'b0, 1'b1);

      // 256 single-nibble words wrap both counters.
      do_reset();
      for (int i = 0; i < 256; i++) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b1);
      cycle(1'b0, 4'h0, 1'b0, 1'b1);
`ifdef NIBBLE_PACKER_STATS_EN
      chk("wrap_word_count", 32'(word_count), 32'd0);
      chk("wrap_pad_count", 32'(pad_count), 32'd0);
`endif

      // Randomized traffic, including PAD-valued data and heavy backpressure.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rnd_d = 4'($urandom_range(0, 15));
         cycle(($urandom_range(0, 3) != 0), rnd_d, ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 2) != 0));
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, 1'b0, 1'b1);
      chk("drain_empty", 32'(out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
